// File: rtl/lsm_pkg.sv
// Shared types and helpers for the LDM/STM sequencer: FSM states, {P,U} addressing codes, popcount.
package lsm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    NEXT,
    DONE
  } lsm_state_e;

  // {P,U} addressing-mode codes
  localparam logic [1:0] MODE_DA = 2'b00;
  localparam logic [1:0] MODE_IA = 2'b01;
  localparam logic [1:0] MODE_DB = 2'b10;
  localparam logic [1:0] MODE_IB = 2'b11;

  localparam logic [31:0] WORD_BYTES = 32'd4;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) begin
      c = c + {4'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/lsm_prio_enc.sv
// Combinational lowest-set-bit finder over a 16-bit register list; no latency, no flow control.
module lsm_prio_enc (
  input  logic [15:0] vec,
  output logic        vld,
  output logic [3:0]  idx
);

  always_comb begin
    idx = 4'd0;
    // Scan high-to-low so the lowest set bit is the last one written.
    for (int i = 15; i >= 0; i--) begin
      if (vec[i]) idx = i[3:0];
    end
  end

  assign vld = |vec;

endmodule

// File: rtl/lsm_sequencer.sv
// LDM/STM sequencer: walks the register list lowest-first, MEM_REQ held until MOC; first MEM_REQ 2 cycles after START.
// Optional MOC watchdog enabled by defining LSM_TIMEOUT_EN.
module lsm_sequencer
  import lsm_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] reg_list,
  input  logic        p_bit,
  input  logic        u_bit,
  input  logic        l_bit,
  input  logic [31:0] base_addr,
  input  logic        moc,
  output logic [3:0]  reg_idx,
  output logic [31:0] addr,
  output logic        mem_req,
  output logic        mem_rw,
  output logic [31:0] wb_addr,
  output logic        busy,
  output logic        lsm_detect,
  output logic        lsm_end,
  output logic        err
);

  lsm_state_e  state, state_nxt;
  logic [15:0] mask;
  logic [15:0] mask_rem;
  logic        p_q, u_q;
  logic [31:0] base_q;
  logic [4:0]  n;
  logic [31:0] span;
  logic [31:0] start_addr;
  logic        enc_vld;
  logic [3:0]  enc_idx;
  logic        timeout;

  lsm_prio_enc u_enc (
    .vec (mask),
    .vld (enc_vld),
    .idx (enc_idx)
  );

  assign n        = popcount16(mask);
  assign span     = {25'd0, n, 2'b00};
  assign mask_rem = mask & (mask - 16'd1);

  always_comb begin
    start_addr = base_q - span;
    case ({p_q, u_q})
      MODE_IA: start_addr = base_q;
      MODE_IB: start_addr = base_q + WORD_BYTES;
      MODE_DA: start_addr = base_q - span + WORD_BYTES;
      MODE_DB: start_addr = base_q - span;
      default: start_addr = base_q - span;
    endcase
  end

`ifdef LSM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] to_cnt;
  logic          err_q;

  assign timeout = (state == XFER) && !moc && (to_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      // Held at zero outside XFER, so every XFER entry starts a fresh count.
      if (state != XFER) to_cnt <= '0;
      else if (!moc)     to_cnt <= to_cnt + CW'(1);
      if (state == IDLE && start) err_q <= 1'b0;
      else if (timeout)           err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout        = 1'b0;
  assign err            = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    busy      = 1'b1;
    lsm_end   = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = SETUP;
      end
      SETUP: state_nxt = enc_vld ? XFER : DONE;
      XFER: begin
        mem_req = 1'b1;
        if (moc)          state_nxt = (mask_rem == 16'd0) ? DONE : NEXT;
        else if (timeout) state_nxt = DONE;
      end
      NEXT: state_nxt = XFER;
      DONE: begin
        lsm_end   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mask       <= '0;
      p_q        <= 1'b0;
      u_q        <= 1'b0;
      mem_rw     <= 1'b0;
      base_q     <= '0;
      addr       <= '0;
      wb_addr    <= '0;
      reg_idx    <= '0;
      lsm_detect <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          mask   <= reg_list;
          p_q    <= p_bit;
          u_q    <= u_bit;
          mem_rw <= l_bit;
          base_q <= base_addr;
        end
        SETUP: begin
          addr       <= start_addr;
          wb_addr    <= u_q ? base_q + span : base_q - span;
          lsm_detect <= (n != 5'd0);
        end
        XFER: if (moc) begin
          mask <= mask_rem;
          addr <= addr + WORD_BYTES;
        end
        default: ;
      endcase
      // Latch the register index on XFER entry; the mask already reflects completed transfers.
      if (state_nxt == XFER && state != XFER) reg_idx <= enc_idx;
    end
  end

endmodule

// File: tb/tb_lsm_sequencer.sv
// Directed bench for lsm_sequencer with a simple MOC responder and transfer logger.
module tb_lsm_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, p_bit, u_bit, l_bit, moc;
  logic [15:0] reg_list;
  logic [31:0] base_addr;
  logic [3:0]  reg_idx;
  logic [31:0] addr, wb_addr;
  logic        mem_req, mem_rw, busy, lsm_detect, lsm_end, err;

  lsm_sequencer #(.TIMEOUT_CYCLES(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .reg_list   (reg_list),
    .p_bit      (p_bit),
    .u_bit      (u_bit),
    .l_bit      (l_bit),
    .base_addr  (base_addr),
    .moc        (moc),
    .reg_idx    (reg_idx),
    .addr       (addr),
    .mem_req    (mem_req),
    .mem_rw     (mem_rw),
    .wb_addr    (wb_addr),
    .busy       (busy),
    .lsm_detect (lsm_detect),
    .lsm_end    (lsm_end),
    .err        (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // moc_mode: 0 = MOC one cycle after MEM_REQ rises, 1 = held low, 2 = held high
  int   moc_mode = 0;
  logic prev_req = 1'b0;
  initial begin
    moc = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (moc_mode)
        1:       moc = 1'b0;
        2:       moc = 1'b1;
        default: moc = mem_req && prev_req && !moc;
      endcase
      prev_req = mem_req;
    end
  end

  logic [3:0]  q_idx[$];
  logic [31:0] q_addr[$];
  logic        q_rw[$];
  int end_cnt, end_cyc, req_cycles, first_req, start_cyc;

  initial begin
    end_cnt = 0; end_cyc = 0; req_cycles = 0; first_req = -1;
    forever begin
      @(posedge clk);
      #2;
      if (mem_req && moc) begin
        q_idx.push_back(reg_idx);
        q_addr.push_back(addr);
        q_rw.push_back(mem_rw);
      end
      if (mem_req) begin
        req_cycles++;
        if (first_req < 0) first_req = cyc;
      end
      if (lsm_end) begin
        end_cnt++;
        end_cyc = cyc;
      end
    end
  end

  task automatic cycles(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic kick(input logic [15:0] list, input logic p, input logic u, input logic l,
                      input logic [31:0] base, input int hold);
    q_idx.delete(); q_addr.delete(); q_rw.delete();
    end_cnt = 0; req_cycles = 0; first_req = -1;
    reg_list = list; p_bit = p; u_bit = u; l_bit = l; base_addr = base;
    start = 1'b1;
    start_cyc = cyc;
    cycles(hold);
    start = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    for (int i = 0; i < 300 && end_cnt == 0; i++) cycles(1);
    chk({tag, "_end_seen"}, 32'(end_cnt != 0), 32'd1);
    cycles(2);
  endtask

  task automatic chk_xfer(input string tag, input int i, input logic [3:0] idx, input logic [31:0] a,
                          input logic rw);
    if (i < q_idx.size()) begin
      chk({tag, "_idx"}, 32'(q_idx[i]), 32'(idx));
      chk({tag, "_addr"}, q_addr[i], a);
      chk({tag, "_rw"}, 32'(q_rw[i]), 32'(rw));
    end else begin
      chk({tag, "_missing"}, 32'(q_idx.size()), 32'(i + 1));
    end
  endtask

  task automatic test_ia_basic(input string tag);
    kick(16'h0005, 1'b0, 1'b1, 1'b1, 32'h100, 1);
    wait_end(tag);
    chk({tag, "_count"}, 32'(q_idx.size()), 32'd2);
    chk_xfer({tag, "_x0"}, 0, 4'd0, 32'h100, 1'b1);
    chk_xfer({tag, "_x1"}, 1, 4'd2, 32'h104, 1'b1);
    chk({tag, "_wb"}, wb_addr, 32'h108);
    chk({tag, "_end_once"}, 32'(end_cnt), 32'd1);
    chk({tag, "_first_req_lat"}, 32'(first_req - start_cyc), 32'd2);
    chk({tag, "_done_lat"}, 32'(end_cyc - start_cyc), 32'd7);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; reg_list = '0; p_bit = 0; u_bit = 0; l_bit = 0; base_addr = '0;
    cycles(3);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_outs", {24'd0, mem_req, mem_rw, lsm_detect, lsm_end, err, 3'd0}, 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_wb", wb_addr, 32'd0);
    chk("rst_idx", 32'(reg_idx), 32'd0);
    rst = 1'b0;
    cycles(2);

    // 1: IA, two transfers; idle outputs then hold last values
    test_ia_basic("t1");
    chk("t1_addr_hold", addr, 32'h108);
    chk("t1_idx_hold", 32'(reg_idx), 32'd2);
    chk("t1_idle", 32'(busy), 32'd0);

    // 2: DB store; START held 3 cycles must not restart the operation
    kick(16'h8001, 1'b1, 1'b0, 1'b0, 32'h200, 3);
    wait_end("t2");
    chk("t2_count", 32'(q_idx.size()), 32'd2);
    chk_xfer("t2_x0", 0, 4'd0, 32'h1F8, 1'b0);
    chk_xfer("t2_x1", 1, 4'd15, 32'h1FC, 1'b0);
    chk("t2_wb", wb_addr, 32'h1F8);
    chk("t2_detect", 32'(lsm_detect), 32'd1);
    chk("t2_end_once", 32'(end_cnt), 32'd1);

    // 3: empty list
    kick(16'h0000, 1'b0, 1'b1, 1'b1, 32'h40, 1);
    wait_end("t3");
    chk("t3_detect", 32'(lsm_detect), 32'd0);
    chk("t3_no_req", 32'(req_cycles), 32'd0);
    chk("t3_end_lat", 32'(end_cyc - start_cyc), 32'd2);
    chk("t3_wb", wb_addr, 32'h40);

    // 4: IB, full list, wraps through zero
    kick(16'hFFFF, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF0, 1);
    wait_end("t4");
    chk("t4_count", 32'(q_idx.size()), 32'd16);
    chk_xfer("t4_first", 0, 4'd0, 32'hFFFF_FFF4, 1'b1);
    chk_xfer("t4_wrap", 3, 4'd3, 32'h0000_0000, 1'b1);
    chk_xfer("t4_last", 15, 4'd15, 32'h30, 1'b1);
    chk("t4_wb", wb_addr, 32'h30);

    // 5: reset during the third XFER, with START asserted alongside reset
    kick(16'h00FF, 1'b0, 1'b1, 1'b1, 32'h0, 1);
    for (int i = 0; i < 50 && !(q_idx.size() == 2 && mem_req); i++) cycles(1);
    chk("t5_third_idx", 32'(reg_idx), 32'd2);
    chk("t5_third_addr", addr, 32'h8);
    rst = 1'b1;
    start = 1'b1;
    cycles(1);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_req", 32'(mem_req), 32'd0);
    chk("t5_rst_idx", 32'(reg_idx), 32'd0);
    rst = 1'b0;
    start = 1'b0;
    cycles(2);
    chk("t5_still_idle", 32'(busy), 32'd0);
    test_ia_basic("t5_after");

    // 6: MOC stuck low
    moc_mode = 1;
    cycles(1);
`ifdef LSM_TIMEOUT_EN
    kick(16'h0001, 1'b0, 1'b1, 1'b0, 32'h80, 1);
    wait_end("t6_to");
    chk("t6_to_lat", 32'(end_cyc - start_cyc), 32'd10);
    chk("t6_to_err", 32'(err), 32'd1);
    chk("t6_to_noxfer", 32'(q_idx.size()), 32'd0);
`else
    kick(16'h0001, 1'b0, 1'b1, 1'b0, 32'h80, 1);
    cycles(20);
    chk("t6_stall_req", 32'(mem_req), 32'd1);
    chk("t6_stall_busy", 32'(busy), 32'd1);
    chk("t6_stall_err", 32'(err), 32'd0);
    moc_mode = 0;
    wait_end("t6_stall");
    chk("t6_stall_count", 32'(q_idx.size()), 32'd1);
`endif

    // 6b: MOC held high, one transfer per XFER/NEXT pair
    moc_mode = 2;
    cycles(1);
    kick(16'h0003, 1'b0, 1'b1, 1'b1, 32'h10, 1);
    wait_end("t6h");
    chk("t6h_count", 32'(q_idx.size()), 32'd2);
    chk_xfer("t6h_x1", 1, 4'd1, 32'h14, 1'b1);
    chk("t6h_req_cycles", 32'(req_cycles), 32'd2);
    chk("t6h_lat", 32'(end_cyc - start_cyc), 32'd5);
    chk("t6h_err_clr", 32'(err), 32'd0);
    moc_mode = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
